demux16_bit_collector: RTL and testbench

//   Write-side counterpart of the 16:1 single-bit select: accepts (index, bit) pairs and scatters each bit

---
 rtl/demux16_bit_collector.sv | 100 ++++++++++
 tb/tb_demux16_bit_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux16_bit_collector.sv
// Scatters (index, bit) pairs into a 2**SEL_W-bit word and hands the full word off on a valid/ready port.
// Optional DEMUX16_DUP_ERR_EN adds a dup_err pulse for writes to an already-filled index.
module demux16_bit_collector #(
  parameter int SEL_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**SEL_W)-1:0]   out_word,
  output logic [SEL_W:0]          fill_count
`ifdef DEMUX16_DUP_ERR_EN
  ,
  output logic                    dup_err
`endif
);

  localparam int WORD_W = 2**SEL_W;
  localparam logic [SEL_W:0] FILL_ONE = 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  mask;
  logic [WORD_W-1:0]  onehot;
  logic [WORD_W-1:0]  mask_next;
  logic               dup;
  logic               dup_q;

  always_comb begin
    onehot    = '0;
    onehot[in_sel] = 1'b1;
    mask_next = mask | onehot;
    dup       = |(mask & onehot);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= COLLECT;
      word       <= '0;
      mask       <= '0;
      fill_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      dup_q      <= 1'b0;
    end else begin
      dup_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            word[in_sel] <= in_bit;
            mask         <= mask_next;
            dup_q        <= dup;
            // fill_count tracks popcount(mask): only new indices advance it
            if (!dup) fill_count <= fill_count + FILL_ONE;
            if (&mask_next) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= COLLECT;
            word       <= '0;
            mask       <= '0;
            fill_count <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_word = word;

`ifdef DEMUX16_DUP_ERR_EN
  assign dup_err = dup_q;
`else
  logic unused_dup;
  assign unused_dup = dup_q;
`endif

endmodule

// File: tb/tb_demux16_bit_collector.sv
// Self-checking bench for demux16_bit_collector: bench-side word model feeds a scoreboard queue
// that is compared against out_word at each handoff.
module tb_demux16_bit_collector;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_bit, out_ready;
  logic        in_ready, out_valid;
  logic [3:0]  in_sel;
  logic [15:0] out_word;
  logic [4:0]  fill_count;
`ifdef DEMUX16_DUP_ERR_EN
  logic        dup_err;
  int          n_dup;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_word = '0;
  logic [15:0] m_mask = '0;

  demux16_bit_collector #(.SEL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_bit     (in_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .fill_count (fill_count)
`ifdef DEMUX16_DUP_ERR_EN
    ,
    .dup_err    (dup_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pair for one edge and mirrors the write into the bench model.
  task automatic write_pair(input logic [3:0] sel, input logic b);
    in_valid = 1'b1;
    in_sel   = sel;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
`ifdef DEMUX16_DUP_ERR_EN
    if (dup_err === 1'b1) n_dup++;
`endif
    m_word[sel] = b;
    m_mask[sel] = 1'b1;
    if (&m_mask) begin
      exp_q.push_back(m_word);
      m_word = '0;
      m_mask = '0;
    end
  endtask

  task automatic model_reset();
    m_word = '0;
    m_mask = '0;
  endtask

  task automatic drain(input string tag);
    int w;
    logic [15:0] exp_w;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_out_valid_timeout: got %b want 1", tag, out_valid); end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s_scoreboard_empty: got word %h want none pending", tag, out_word);
    end else begin
      exp_w = exp_q.pop_front();
      if (out_word !== exp_w) begin n_fail++; $display("FAIL %s_word: got %h want %h", tag, out_word, exp_w); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill_count !== 5'd0 || out_word !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s_handoff: got v=%b r=%b fc=%0d w=%h want v=0 r=1 fc=0 w=0000", tag, out_valid, in_ready, fill_count, out_word);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sel = '0; in_bit = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word !== 16'h0000 || fill_count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: got r=%b v=%b w=%h fc=%0d want r=1 v=0 w=0000 fc=0", in_ready, out_valid, out_word, fill_count);
    end
`ifdef DEMUX16_DUP_ERR_EN
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL reset_dup_err: got %b want 0", dup_err); end
`endif
  endtask

  task automatic test_ascending();
    logic [15:0] d;
    d = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      write_pair(4'(i), d[i]);
      if (i == 14) begin
        n_checks++;
        if (out_valid !== 1'b0 || fill_count !== 5'd15 || out_word !== 16'h25C3) begin
          n_fail++;
          $display("FAIL asc_partial: got v=%b fc=%0d w=%h want v=0 fc=15 w=25c3", out_valid, fill_count, out_word);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || fill_count !== 5'd16) begin
      n_fail++;
      $display("FAIL asc_hold_latency: got v=%b r=%b fc=%0d want v=1 r=0 fc=16", out_valid, in_ready, fill_count);
    end
    drain("asc");
  endtask

  task automatic test_descending_stall();
    logic [15:0] d;
    d = 16'h1234;
    for (int i = 15; i >= 0; i--) write_pair(4'(i), d[i]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_sel = 4'($urandom_range(0, 15));
      in_bit = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (out_word !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0 || fill_count !== 5'd16) begin
        n_fail++;
        $display("FAIL desc_stall_%0d: got w=%h v=%b r=%b fc=%0d want w=1234 v=1 r=0 fc=16", c, out_word, out_valid, in_ready, fill_count);
      end
    end
    in_valid = 1'b0;
    drain("desc");
  endtask

  task automatic test_duplicate();
`ifdef DEMUX16_DUP_ERR_EN
    n_dup = 0;
`endif
    write_pair(4'd3, 1'b1);
`ifdef DEMUX16_DUP_ERR_EN
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL dup_first_write: got %b want 0", dup_err); end
`endif
    write_pair(4'd3, 1'b0);
    n_checks++;
    if (fill_count !== 5'd1 || out_word !== 16'h0000) begin
      n_fail++;
      $display("FAIL dup_overwrite: got fc=%0d w=%h want fc=1 w=0000", fill_count, out_word);
    end
`ifdef DEMUX16_DUP_ERR_EN
    n_checks++;
    if (dup_err !== 1'b1) begin n_fail++; $display("FAIL dup_pulse: got %b want 1", dup_err); end
`endif
    for (int i = 0; i < 16; i++) if (i != 3) write_pair(4'(i), 1'b1);
`ifdef DEMUX16_DUP_ERR_EN
    n_checks++;
    if (n_dup != 1) begin n_fail++; $display("FAIL dup_pulse_count: got %0d want 1", n_dup); end
`endif
    drain("dup");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) write_pair(4'(i), 1'b1);
    n_checks++;
    if (fill_count !== 5'd8 || out_word !== 16'h00FF) begin
      n_fail++;
      $display("FAIL clr_prefill: got fc=%0d w=%h want fc=8 w=00ff", fill_count, out_word);
    end
    clear = 1'b1; in_valid = 1'b1; in_sel = 4'd8; in_bit = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    n_checks++;
    if (fill_count !== 5'd0 || out_word !== 16'h0000 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_collect: got fc=%0d w=%h r=%b v=%b want fc=0 w=0000 r=1 v=0", fill_count, out_word, in_ready, out_valid);
    end
    for (int i = 0; i < 16; i++) write_pair(4'(i), 1'(16'hBEEF >> i));
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL clr_hold_setup: got v=%b w=%h want v=1 w=beef", out_valid, out_word);
    end
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    void'(exp_q.pop_back());
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== 16'h0000 || fill_count !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_hold: got v=%b w=%h fc=%0d r=%b want v=0 w=0000 fc=0 r=1", out_valid, out_word, fill_count, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) write_pair(4'(i), 1'b1);
    n_checks++;
    if (fill_count !== 5'd10) begin n_fail++; $display("FAIL rst_mid_prefill: got %0d want 10", fill_count); end
    reset = 1'b1; in_valid = 1'b1; in_sel = 4'd12;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word !== 16'h0000 || fill_count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got r=%b v=%b w=%h fc=%0d want r=1 v=0 w=0000 fc=0", in_ready, out_valid, out_word, fill_count);
    end
    for (int i = 0; i < 16; i++) write_pair(4'(i), 1'(16'h5A5A >> i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_back());
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word !== 16'h0000 || fill_count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_hold: got r=%b v=%b w=%h fc=%0d want r=1 v=0 w=0000 fc=0", in_ready, out_valid, out_word, fill_count);
    end
  endtask

  // Random index order plus back-to-back words with the minimum one-cycle gap after handoff.
  task automatic test_back_to_back();
    logic [3:0] order[16];
    logic [15:0] d;
    int j;
    logic [3:0] t;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 16; i++) order[i] = 4'(i);
      for (int i = 15; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      d = 16'($urandom);
      for (int i = 0; i < 16; i++) write_pair(order[i], d[order[i]]);
      drain("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending_stall();
    test_duplicate();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
